// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one memory bus between instruction-fetch and data ports.
// Build option: define MEM_ARBITER_RR_EN for round-robin on simultaneous requests.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        iready,
  output logic [31:0] i_data,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        dready,
  output logic [31:0] d_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_ren,
  output logic        bus_wen,
  input  logic [31:0] bus_rdata,
  input  logic        bus_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        bus_ren_q, bus_ren_d;
  logic        bus_wen_q, bus_wen_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] i_data_q, i_data_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        iready_q, iready_d;
  logic        dready_q, dready_d;
  logic        data_req;
  logic        pick_data;

`ifdef MEM_ARBITER_RR_EN
  // Set when the data port won the most recent grant.
  logic        last_data_q, last_data_d;
`endif

  always_comb begin
    state_d     = state_q;
    bus_ren_d   = bus_ren_q;
    bus_wen_d   = bus_wen_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    i_data_d    = i_data_q;
    d_rdata_d   = d_rdata_q;
    iready_d    = 1'b0;
    dready_d    = 1'b0;
    data_req    = d_ren | d_wen;
`ifdef MEM_ARBITER_RR_EN
    last_data_d = last_data_q;
    pick_data   = data_req & (~i_req | ~last_data_q);
`else
    pick_data   = data_req;
`endif

    case (state_q)
      IDLE: begin
        if (pick_data) begin
          // A write wins when both strobes are raised together.
          state_d     = DATA;
          bus_addr_d  = d_addr;
          bus_wdata_d = d_wdata;
          bus_wen_d   = d_wen;
          bus_ren_d   = ~d_wen;
`ifdef MEM_ARBITER_RR_EN
          last_data_d = 1'b1;
`endif
        end else if (i_req) begin
          state_d    = FETCH;
          bus_addr_d = i_addr;
          bus_ren_d  = 1'b1;
          bus_wen_d  = 1'b0;
`ifdef MEM_ARBITER_RR_EN
          last_data_d = 1'b0;
`endif
        end
      end
      FETCH: begin
        if (!bus_busy) begin
          i_data_d  = bus_rdata;
          iready_d  = 1'b1;
          bus_ren_d = 1'b0;
          state_d   = DONE;
        end
      end
      DATA: begin
        if (!bus_busy) begin
          if (!bus_wen_q) begin
            d_rdata_d = bus_rdata;
          end
          dready_d  = 1'b1;
          bus_ren_d = 1'b0;
          bus_wen_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        // One dead cycle so a held request cannot be regranted on its ready pulse.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_ren_q   <= 1'b0;
      bus_wen_q   <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      i_data_q    <= 32'd0;
      d_rdata_q   <= 32'd0;
      iready_q    <= 1'b0;
      dready_q    <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_ren_q   <= bus_ren_d;
      bus_wen_q   <= bus_wen_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      i_data_q    <= i_data_d;
      d_rdata_q   <= d_rdata_d;
      iready_q    <= iready_d;
      dready_q    <= dready_d;
`ifdef MEM_ARBITER_RR_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  assign bus_ren   = bus_ren_q;
  assign bus_wen   = bus_wen_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign i_data    = i_data_q;
  assign d_rdata   = d_rdata_q;
  assign iready    = iready_q;
  assign dready    = dready_q;

endmodule
`default_nettype wire
